// File: rtl/nv_param_commit.sv
// Staged parameter bank with atomic commit to the active bank on a solver tick.
// Writes always land in staging; the active bank only changes on an ARMED tick.
module nv_param_commit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_WIDTH       = 20
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  wr_en,
  input  logic [1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  commit_req,
  input  logic                  sample_tick,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] param_0,
  output logic [DATA_WIDTH-1:0] param_1,
  output logic [DATA_WIDTH-1:0] param_2,
  output logic [DATA_WIDTH-1:0] param_3,
  output logic                  param_update,
  output logic                  busy,
  output logic [3:0]            dirty,
  output logic                  overrun,
  output logic                  timeout,
  output logic [15:0]           commit_cnt
);

  // state | meaning
  // IDLE  | no commit pending; ticks ignored
  // ARMED | commit requested; waiting for sample_tick or timeout
  // APPLY | new active bank visible; param_update high for this cycle
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  localparam bit                TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] stage [4];
  logic [TO_WIDTH-1:0]   to_cnt;
  logic                  capture;
  logic                  expire;
  logic [3:0]            wr_bit;

  assign wr_bit = wr_en ? (4'b0001 << wr_addr) : 4'b0000;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    expire    = 1'b0;
    case (state)
      S_IDLE: begin
        if (commit_req) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (sample_tick) begin
          capture   = 1'b1;
          state_nxt = S_APPLY;
        end else if (TO_EN && (to_cnt == TO_LAST)) begin
          expire    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_APPLY: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      param_update <= 1'b0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != S_IDLE);
      param_update <= capture;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) stage[i] <= '0;
    end else if (wr_en) begin
      stage[wr_addr] <= wr_data;
    end
  end

  // Active bank reads staging before any same-cycle write lands.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      param_0    <= '0;
      param_1    <= '0;
      param_2    <= '0;
      param_3    <= '0;
      commit_cnt <= '0;
    end else if (capture) begin
      param_0    <= stage[0];
      param_1    <= stage[1];
      param_2    <= stage[2];
      param_3    <= stage[3];
      commit_cnt <= commit_cnt + 16'd1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      dirty <= 4'b0000;
    end else if (capture) begin
      dirty <= wr_bit;
    end else begin
      dirty <= dirty | wr_bit;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      to_cnt <= '0;
    end else if ((state == S_IDLE) && commit_req) begin
      to_cnt <= '0;
    end else if (state == S_ARMED) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Set conditions take priority over clr_err.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (wr_en && (state == S_ARMED)) overrun <= 1'b1;
      else if (clr_err)                overrun <= 1'b0;
      if (expire)       timeout <= 1'b1;
      else if (clr_err) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nv_param_commit.sv
// Scoreboard bench for nv_param_commit: expected banks are queued when a capturing
// tick is driven and compared when param_update is observed.
module tb_nv_param_commit;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        commit_req;
  logic        sample_tick;
  logic        clr_err;
  logic [31:0] param_0, param_1, param_2, param_3;
  logic        param_update;
  logic        busy;
  logic [3:0]  dirty;
  logic        overrun;
  logic        timeout;
  logic [15:0] commit_cnt;

  nv_param_commit #(
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16),
    .TO_WIDTH      (5)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit_req  (commit_req),
    .sample_tick (sample_tick),
    .clr_err     (clr_err),
    .param_0     (param_0),
    .param_1     (param_1),
    .param_2     (param_2),
    .param_3     (param_3),
    .param_update(param_update),
    .busy        (busy),
    .dirty       (dirty),
    .overrun     (overrun),
    .timeout     (timeout),
    .commit_cnt  (commit_cnt)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] p3;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last_e;
  logic [31:0] stg_m [4];
  logic [15:0] cnt_m;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_upd    = 0;
  int          n_exp    = 0;
  logic        prev_upd = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle of stimulus; cap=1 means this tick must capture the staging bank.
  task automatic drive(input bit we, input logic [1:0] a, input logic [31:0] d,
                       input bit req, input bit tick, input bit clr, input bit cap);
    exp_t e;
    if (cap) begin
      cnt_m = cnt_m + 16'd1;
      e.p0  = stg_m[0];
      e.p1  = stg_m[1];
      e.p2  = stg_m[2];
      e.p3  = stg_m[3];
      e.cnt = cnt_m;
      sb_q.push_back(e);
      last_e = e;
      n_exp++;
    end
    wr_en       = we;
    wr_addr     = a;
    wr_data     = d;
    commit_req  = req;
    sample_tick = tick;
    clr_err     = clr;
    @(posedge ACLK);
    #1;
    wr_en       = 1'b0;
    wr_addr     = 2'd0;
    wr_data     = '0;
    commit_req  = 1'b0;
    sample_tick = 1'b0;
    clr_err     = 1'b0;
    if (we) stg_m[a] = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge ACLK) begin
    if (ARESETN === 1'b1 && param_update === 1'b1) begin
      exp_t e;
      n_upd++;
      if (prev_upd) chk("upd_single_pulse", 64'(prev_upd), 64'd0);
      if (sb_q.size() == 0) begin
        chk("spurious_update", 64'(param_update), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_param_0", 64'(param_0), 64'(e.p0));
        chk("sb_param_1", 64'(param_1), 64'(e.p1));
        chk("sb_param_2", 64'(param_2), 64'(e.p2));
        chk("sb_param_3", 64'(param_3), 64'(e.p3));
        chk("sb_commit_cnt", 64'(commit_cnt), 64'(e.cnt));
      end
    end
    prev_upd = (ARESETN === 1'b1) && (param_update === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int upd_before;
    ARESETN     = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = 2'd0;
    wr_data     = '0;
    commit_req  = 1'b0;
    sample_tick = 1'b0;
    clr_err     = 1'b0;
    for (int i = 0; i < 4; i++) stg_m[i] = '0;
    cnt_m  = '0;
    last_e = '0;

    #100 ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
    chk("rst_param_0", 64'(param_0), 64'd0);
    chk("rst_param_3", 64'(param_3), 64'd0);
    chk("rst_update", 64'(param_update), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dirty", 64'(dirty), 64'd0);
    chk("rst_flags", 64'({overrun, timeout}), 64'd0);
    chk("rst_cnt", 64'(commit_cnt), 64'd0);

    // Ticks with nothing armed change nothing.
    repeat (3) drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("idle_tick_param_0", 64'(param_0), 64'd0);
    chk("idle_tick_cnt", 64'(commit_cnt), 64'd0);
    chk("idle_tick_busy", 64'(busy), 64'd0);

    // Basic commit.
    for (int i = 0; i < 4; i++) drive(1'b1, 2'(i), 32'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("basic_dirty_staged", 64'(dirty), 64'hF);
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("basic_busy_after_req", 64'(busy), 64'd1);
    idle(4);
    chk("basic_dirty_pre_tick", 64'(dirty), 64'hF);
    chk("basic_param_0_pre_tick", 64'(param_0), 64'd0);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("basic_update", 64'(param_update), 64'd1);
    chk("basic_param_2", 64'(param_2), 64'd3);
    chk("basic_dirty_post", 64'(dirty), 64'd0);
    chk("basic_cnt", 64'(commit_cnt), 64'd1);
    idle(1);
    chk("basic_update_end", 64'(param_update), 64'd0);
    chk("basic_busy_end", 64'(busy), 64'd0);

    // Overrun in the capture cycle.
    drive(1'b1, 2'd0, 32'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd0, 32'hB, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovr_param_0", 64'(param_0), 64'hA);
    chk("ovr_dirty", 64'(dirty), 64'b0001);
    chk("ovr_flag", 64'(overrun), 64'd1);
    idle(1);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_cleared", 64'(overrun), 64'd0);
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovr_staged_b", 64'(param_0), 64'hB);
    idle(1);

    // Set beats clear in the same cycle.
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 32'h7, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_set_wins", 64'(overrun), 64'd1);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovr_param_1", 64'(param_1), 64'h7);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_cleared2", 64'(overrun), 64'd0);

    // Timeout after 16 armed cycles.
    drive(1'b1, 2'd2, 32'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(15);
    chk("to_busy_before", 64'(busy), 64'd1);
    chk("to_flag_before", 64'(timeout), 64'd0);
    idle(1);
    chk("to_flag", 64'(timeout), 64'd1);
    chk("to_busy", 64'(busy), 64'd0);
    chk("to_param_2", 64'(param_2), 64'(last_e.p2));
    chk("to_cnt", 64'(commit_cnt), 64'(cnt_m));
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("to_cleared", 64'(timeout), 64'd0);

    // Request and tick together in IDLE only arms.
    upd_before = n_upd;
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sim_busy", 64'(busy), 64'd1);
    chk("sim_no_update", 64'(param_update), 64'd0);
    idle(1);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("sim_param_2", 64'(param_2), 64'h99);
    idle(1);
    chk("sim_one_update", 64'(n_upd - upd_before), 64'd1);
    chk("sim_cnt", 64'(commit_cnt), 64'(cnt_m));

    // Reset while ARMED discards the commit.
    drive(1'b1, 2'd0, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    ARESETN = 1'b0;
    #20;
    ARESETN = 1'b1;
    for (int i = 0; i < 4; i++) stg_m[i] = '0;
    cnt_m = '0;
    idle(1);
    chk("mid_rst_param_0", 64'(param_0), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_dirty", 64'(dirty), 64'd0);
    chk("mid_rst_cnt", 64'(commit_cnt), 64'd0);
    upd_before = n_upd;
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("mid_rst_no_update", 64'(n_upd - upd_before), 64'd0);

    // commit_cnt wrap from a preloaded 0xFFFF.
    @(negedge ACLK);
    force dut.commit_cnt = 16'hFFFF;
    #1;
    release dut.commit_cnt;
    cnt_m = 16'hFFFF;
    @(posedge ACLK);
    #1;
    chk("wrap_preload", 64'(commit_cnt), 64'hFFFF);
    drive(1'b1, 2'd3, 32'hC0DE, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("wrap_cnt", 64'(commit_cnt), 64'd0);
    chk("wrap_param_3", 64'(param_3), 64'hC0DE);
    idle(2);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    chk("update_total", 64'(n_upd), 64'(n_exp));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
